// File: rtl/sized_data_memory.sv
// Byte-addressed big-endian data memory with byte/halfword/word access, load
// extension and valid/ready handshake. Define MEM_CLEAR_EN to zero the array after reset.
module sized_data_memory #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESP  = 2'd1
`ifdef MEM_CLEAR_EN
    ,S_CLEAR = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic              accept, size_bad, range_bad, align_bad, req_err, store_en;
  logic [31:0]       load_ext;

`ifdef MEM_CLEAR_EN
  localparam int CLR_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(DEPTH / 4 - 1);
  logic [CLR_W-1:0]  clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0] clr_base;
  logic              clr_we;
  assign clr_base = ADDR_W'({clr_idx_q, 2'b00});
  assign clr_we   = (state_q == S_CLEAR) && !rst;
`endif

  // Only aligned accesses reach the array, so the trailing bytes are the base with low bits set.
  assign a0 = req_addr[ADDR_W-1:0];
  assign a1 = a0 | ADDR_W'(1);
  assign a2 = a0 | ADDR_W'(2);
  assign a3 = a0 | ADDR_W'(3);

  assign size_bad  = (req_size == 2'b11);
  assign range_bad = ((req_addr >> ADDR_W) != 32'd0);
  assign align_bad = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err   = size_bad || range_bad || align_bad;

  assign accept   = (state_q == S_IDLE) && req_valid && !rst;
  assign store_en = accept && req_write && !req_err;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    load_ext = '0;
    case (req_size)
      2'b00:   load_ext = req_unsigned ? {24'h0, mem[a0]} : {{24{mem[a0][7]}}, mem[a0]};
      2'b01:   load_ext = req_unsigned ? {16'h0, mem[a0], mem[a1]}
                                       : {{16{mem[a0][7]}}, mem[a0], mem[a1]};
      2'b10:   load_ext = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef MEM_CLEAR_EN
    clr_idx_d   = clr_idx_q;
`endif
    case (state_q)
`ifdef MEM_CLEAR_EN
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == CLR_LAST) state_d = S_IDLE;
      end
`endif
      S_IDLE: begin
        if (accept) begin
          state_d     = S_RESP;
          rsp_err_d   = req_err;
          rsp_rdata_d = (req_err || req_write) ? '0 : load_ext;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef MEM_CLEAR_EN
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
`else
      state_q   <= S_IDLE;
`endif
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
`ifdef MEM_CLEAR_EN
      clr_idx_q <= clr_idx_d;
`endif
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_EN
    if (clr_we) begin
      for (int unsigned k = 0; k < 4; k++) mem[clr_base | ADDR_W'(k)] <= '0;
    end else
`endif
    if (store_en) begin
      case (req_size)
        2'b00: mem[a0] <= req_wdata[7:0];
        2'b01: begin
          mem[a0] <= req_wdata[15:8];
          mem[a1] <= req_wdata[7:0];
        end
        2'b10: begin
          mem[a0] <= req_wdata[31:24];
          mem[a1] <= req_wdata[23:16];
          mem[a2] <= req_wdata[15:8];
          mem[a3] <= req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end
endmodule
